// File: rtl/cv32e40p_apu_core_pkg.sv
// Shared APU writeback types and constants.
package cv32e40p_apu_core_pkg;

  localparam int unsigned APU_WB_BUF_DEPTH  = 2;
  localparam int unsigned APU_WB_ADDR_WIDTH = 6;
  localparam int unsigned APU_WB_DATA_WIDTH = 32;
  localparam int unsigned APU_NUSFLAGS_CPU  = 5;

  // One buffered writeback; field order matches the {waddr, wdata} packing used by the buffer.
  typedef struct packed {
    logic [APU_WB_ADDR_WIDTH-1:0] waddr;
    logic [APU_WB_DATA_WIDTH-1:0] wdata;
  } apu_wb_entry_t;

endpackage

// File: rtl/cv32e40p_apu_wb_fifo.sv
// Generic circular FIFO: wrapping pointers, occupancy count, full/empty.
module cv32e40p_apu_wb_fifo
  import cv32e40p_apu_core_pkg::*;
#(
  parameter int unsigned DEPTH = APU_WB_BUF_DEPTH,
  parameter int unsigned WIDTH = APU_WB_ADDR_WIDTH + APU_WB_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rptr;
  logic [PTR_W-1:0] wptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH-1 so non-power-of-two depths stay dense.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Status flags and guarded push/pop; a push into a full FIFO needs a same-cycle pop.
  always_comb begin
    full    = (count == CNT_W'(DEPTH));
    empty   = (count == '0);
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    rdata   = mem[rptr];
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= next_ptr(wptr);
      if (do_pop)  rptr <= next_ptr(rptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; validity is tracked by count, so data needs no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/cv32e40p_apu_wb_buffer.sv
// APU result writeback buffer: bypass when empty, in-order retirement otherwise.
module cv32e40p_apu_wb_buffer
  import cv32e40p_apu_core_pkg::*;
#(
  parameter int unsigned DEPTH       = APU_WB_BUF_DEPTH,
  parameter int unsigned DATA_WIDTH  = APU_WB_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = APU_WB_ADDR_WIDTH,
  parameter int unsigned FLAGS_WIDTH = APU_NUSFLAGS_CPU
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        apu_rvalid_i,
  input  logic [DATA_WIDTH-1:0]       apu_result_i,
  input  logic [FLAGS_WIDTH-1:0]      apu_flags_i,
  input  logic [ADDR_WIDTH-1:0]       apu_waddr_i,
  input  logic                        apu_wb_disable_i,
  input  logic                        wb_ready_i,
  output logic                        wb_we_o,
  output logic [ADDR_WIDTH-1:0]       wb_waddr_o,
  output logic [DATA_WIDTH-1:0]       wb_wdata_o,
  output logic                        fflags_we_o,
  output logic [FLAGS_WIDTH-1:0]      fflags_o,
  output logic [$clog2(DEPTH+1)-1:0]  count_o,
  output logic                        almost_full_o,
  output logic                        overflow_o
);

  localparam int unsigned CNT_W   = $clog2(DEPTH+1);
  localparam int unsigned ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

  logic               rvalid;
  logic               accept;
  logic               bypass;
  logic               push;
  logic               pop;
  logic               overflow_set;
  logic               empty;
  logic               full;
  logic [ENTRY_W-1:0] head;
  logic [ENTRY_W-1:0] new_entry;

  // Arrival qualification; results arriving during reset are ignored.
  always_comb begin
    rvalid       = apu_rvalid_i & ~rst;
    accept       = rvalid & ~apu_wb_disable_i;
    bypass       = empty & accept;
    pop          = ~empty & wb_ready_i;
    push         = accept & ~(bypass & wb_ready_i) & (~full | pop);
    overflow_set = accept & full & ~pop;
    new_entry    = {apu_waddr_i, apu_result_i};
  end

  cv32e40p_apu_wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (new_entry),
    .rdata (head),
    .count (count_o),
    .full  (full),
    .empty (empty)
  );

  // Write-port selection: queued head first, zero-latency bypass only when empty.
  always_comb begin
    wb_we_o    = 1'b0;
    wb_waddr_o = '0;
    wb_wdata_o = '0;
    if (!empty) begin
      wb_we_o                  = 1'b1;
      {wb_waddr_o, wb_wdata_o} = head;
    end else if (bypass) begin
      wb_we_o    = 1'b1;
      wb_waddr_o = apu_waddr_i;
      wb_wdata_o = apu_result_i;
    end
  end

  // Flag strobe follows every returning result, written back or not.
  always_comb begin
    fflags_we_o   = rvalid;
    fflags_o      = rst ? '0 : apu_flags_i;
    almost_full_o = (count_o >= CNT_W'(DEPTH-1));
  end

  // Sticky overflow: a result was lost because the buffer was full and stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_o <= 1'b0;
    end else if (overflow_set) begin
      overflow_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cv32e40p_apu_wb_buffer.sv
// Scoreboard bench for the APU writeback buffer.
module tb_cv32e40p_apu_wb_buffer;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 6;
  localparam int unsigned FW    = 5;
  localparam int unsigned CW    = $clog2(DEPTH+1);

  logic          clk;
  logic          rst;
  logic          apu_rvalid_i;
  logic [DW-1:0] apu_result_i;
  logic [FW-1:0] apu_flags_i;
  logic [AW-1:0] apu_waddr_i;
  logic          apu_wb_disable_i;
  logic          wb_ready_i;
  logic          wb_we_o;
  logic [AW-1:0] wb_waddr_o;
  logic [DW-1:0] wb_wdata_o;
  logic          fflags_we_o;
  logic [FW-1:0] fflags_o;
  logic [CW-1:0] count_o;
  logic          almost_full_o;
  logic          overflow_o;

  cv32e40p_apu_wb_buffer #(
    .DEPTH       (DEPTH),
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .FLAGS_WIDTH (FW)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .apu_rvalid_i     (apu_rvalid_i),
    .apu_result_i     (apu_result_i),
    .apu_flags_i      (apu_flags_i),
    .apu_waddr_i      (apu_waddr_i),
    .apu_wb_disable_i (apu_wb_disable_i),
    .wb_ready_i       (wb_ready_i),
    .wb_we_o          (wb_we_o),
    .wb_waddr_o       (wb_waddr_o),
    .wb_wdata_o       (wb_wdata_o),
    .fflags_we_o      (fflags_we_o),
    .fflags_o         (fflags_o),
    .count_o          (count_o),
    .almost_full_o    (almost_full_o),
    .overflow_o       (overflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: queue of results still owed to the write port, in order.
  logic [AW+DW-1:0] exp_q[$];
  logic             mov     = 1'b0;
  logic             exp_ov  = 1'b0;
  int               exp_cnt = 0;
  logic             exp_we  = 1'b0;
  logic             exp_fwe = 1'b0;
  logic [FW-1:0]    exp_fl  = '0;
  logic             exp_rdy = 1'b0;
  bit               mon_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of stimulus and record what the buffer owes for it.
  task automatic cycle(input logic rv, input logic [DW-1:0] res, input logic [FW-1:0] fl,
                       input logic [AW-1:0] wa, input logic dis, input logic rdy);
    int   held;
    logic acc;
    logic drop;
    apu_rvalid_i     = rv;
    apu_result_i     = res;
    apu_flags_i      = fl;
    apu_waddr_i      = wa;
    apu_wb_disable_i = dis;
    wb_ready_i       = rdy;
    held    = exp_q.size();
    acc     = rv && !dis;
    drop    = acc && (held == int'(DEPTH)) && !rdy;
    exp_cnt = held;
    exp_ov  = mov;
    exp_we  = (held > 0) || acc;
    exp_fwe = rv;
    exp_fl  = fl;
    exp_rdy = rdy;
    if (acc && !drop) exp_q.push_back({wa, res});
    if (drop) mov = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    cycle(1'b0, '0, '0, '0, 1'b0, rdy);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    mon_en = 1'b0;
    #3;
    rst              = 1'b1;
    apu_rvalid_i     = 1'b1;
    apu_wb_disable_i = 1'b0;
    wb_ready_i       = 1'b1;
    apu_result_i     = $urandom;
    apu_flags_i      = FW'($urandom);
    apu_waddr_i      = AW'($urandom);
    #1;
    chk("rst_count",    64'(count_o), 64'(0));
    chk("rst_overflow", 64'(overflow_o), 64'(0));
    chk("rst_wb_we",    64'(wb_we_o), 64'(0));
    chk("rst_waddr",    64'(wb_waddr_o), 64'(0));
    chk("rst_wdata",    64'(wb_wdata_o), 64'(0));
    chk("rst_fflags_we", 64'(fflags_we_o), 64'(0));
    chk("rst_fflags",   64'(fflags_o), 64'(0));
    chk("rst_almost_full", 64'(almost_full_o), 64'(0));
    apu_rvalid_i = 1'b0;
    exp_q.delete();
    mov = 1'b0;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    mon_en = 1'b1;
  endtask

  // Monitor: compares every cycle's outputs against the model, retiring on wb_ready_i.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("count",       64'(count_o), 64'(exp_cnt));
      chk("almost_full", 64'(almost_full_o), 64'(exp_cnt >= int'(DEPTH) - 1));
      chk("overflow",    64'(overflow_o), 64'(exp_ov));
      chk("wb_we",       64'(wb_we_o), 64'(exp_we));
      chk("fflags_we",   64'(fflags_we_o), 64'(exp_fwe));
      chk("fflags",      64'(fflags_o), 64'(exp_fl));
      if (exp_we) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL scoreboard: write expected but model queue empty at %0t", $time);
        end else begin
          chk("wb_waddr", 64'(wb_waddr_o), 64'(exp_q[0][AW+DW-1:DW]));
          chk("wb_wdata", 64'(wb_wdata_o), 64'(exp_q[0][DW-1:0]));
          if (exp_rdy) void'(exp_q.pop_front());
        end
      end else begin
        chk("idle_waddr", 64'(wb_waddr_o), 64'(0));
        chk("idle_wdata", 64'(wb_wdata_o), 64'(0));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b1;
    apu_rvalid_i     = 1'b0;
    apu_result_i     = '0;
    apu_flags_i      = '0;
    apu_waddr_i      = '0;
    apu_wb_disable_i = 1'b0;
    wb_ready_i       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("init_count",    64'(count_o), 64'(0));
    chk("init_overflow", 64'(overflow_o), 64'(0));
    chk("init_wb_we",    64'(wb_we_o), 64'(0));
    rst    = 1'b0;
    mon_en = 1'b1;

    // Bypass when empty and ready.
    cycle(1'b1, 32'h3F800000, 5'b00001, 6'h25, 1'b0, 1'b1);
    idle(1'b1);

    // Stalled single result, then retire.
    cycle(1'b1, 32'hAAAA0001, 5'b00000, 6'h21, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);

    // Fill, overflow on third, drain in order.
    cycle(1'b1, 32'h00000011, 5'b00010, 6'h01, 1'b0, 1'b0);
    cycle(1'b1, 32'h00000022, 5'b00100, 6'h02, 1'b0, 1'b0);
    cycle(1'b1, 32'h00000033, 5'b01000, 6'h03, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Simultaneous pop and push with one entry held.
    cycle(1'b1, 32'h0000AAAA, 5'b00000, 6'h0A, 1'b0, 1'b0);
    cycle(1'b1, 32'h0000BBBB, 5'b00000, 6'h0B, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Write-disabled result only strobes flags.
    cycle(1'b1, 32'hDEADBEEF, 5'b10000, 6'h30, 1'b1, 1'b1);
    cycle(1'b1, 32'h12345678, 5'b10000, 6'h31, 1'b1, 1'b0);
    idle(1'b1);

    // Full and push with same-cycle pop: accepted, no overflow.
    do_reset();
    cycle(1'b1, 32'h000000A1, 5'b00000, 6'h11, 1'b0, 1'b0);
    cycle(1'b1, 32'h000000B2, 5'b00000, 6'h12, 1'b0, 1'b0);
    cycle(1'b1, 32'h000000C3, 5'b00000, 6'h13, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Mid-drain reset with overflow set: nothing written afterwards.
    cycle(1'b1, 32'h00000111, 5'b00000, 6'h04, 1'b0, 1'b0);
    cycle(1'b1, 32'h00000222, 5'b00000, 6'h05, 1'b0, 1'b0);
    cycle(1'b1, 32'h00000333, 5'b00000, 6'h06, 1'b0, 1'b0);
    idle(1'b0);
    do_reset();
    idle(1'b1);
    idle(1'b1);

    // Randomized bursts, each starting from reset so overflow can re-arm.
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 500; i++) begin
        cycle(($urandom % 3) != 0, $urandom, FW'($urandom), AW'($urandom),
              ($urandom % 6) == 0, ($urandom % 2) == 0);
      end
      for (int i = 0; i < 4; i++) idle(1'b1);
      do_reset();
    end

    idle(1'b1);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
